// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared state encoding and counter sizing for the step clock controller
package clock_ctrl_pkg;

   localparam logic [2:0] ENC_IDLE   = 3'd0;
   localparam logic [2:0] ENC_HELD   = 3'd1;
   localparam logic [2:0] ENC_REPEAT = 3'd2;
   localparam logic [2:0] ENC_AUTO   = 3'd3;
   localparam logic [2:0] ENC_HALTED = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ENC_IDLE,
      ST_HELD   = ENC_HELD,
      ST_REPEAT = ENC_REPEAT,
      ST_AUTO   = ENC_AUTO,
      ST_HALTED = ENC_HALTED
   } state_t;

   // Width of the shared counter: enough bits to hold (largest period - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector against a one-cycle-delayed copy
module rise_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sig_in,
   output logic pulse
);

   logic sig_q;

   // Delayed copy; reset value chosen by the user so a level already high at release is not an edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sig_q <= RESET_VAL;
      else          sig_q <= sig_in;
   end

   assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// rtl/step_clock_ctrl.sv - single-step / auto-repeat / auto-run CPU clock-enable generator
module step_clock_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int AUTO_DIV     = 1000,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 200
) (
   input  logic clock,
   input  logic reset_n,
   input  logic step_in,
   input  logic run_in,
   input  logic hlt,
   output logic tick,
   output logic running,
   output logic halted
);

   localparam int CW = cnt_width(AUTO_DIV, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CW-1:0] AUTO_TERM  = CW'(AUTO_DIV - 1);
   localparam logic [CW-1:0] DELAY_TERM = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_TERM  = CW'(REPEAT_RATE - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          tick_q, tick_nxt;
   logic          step_rise;

   // Held switch at reset release must not look like a press, so the delayed copy resets high.
   rise_detect #(.RESET_VAL(1'b1)) u_step_rise (
      .clock   (clock),
      .reset_n (reset_n),
      .sig_in  (step_in),
      .pulse   (step_rise)
   );

   // State, shared counter and registered tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         tick_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         tick_q <= tick_nxt;
      end
   end

   // Next state; halt wins over everything, and leaving a counting state never emits a tick.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tick_nxt  = 1'b0;
      if (hlt) begin
         state_nxt = ST_HALTED;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run_in) begin
                  state_nxt = ST_AUTO;
                  cnt_nxt   = '0;
               end else if (step_rise) begin
                  state_nxt = ST_HELD;
                  cnt_nxt   = '0;
                  tick_nxt  = 1'b1;
               end
            end
            ST_HELD: begin
               if (!step_in) begin
                  state_nxt = ST_IDLE;
               end else if (cnt == DELAY_TERM) begin
                  state_nxt = ST_REPEAT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            ST_REPEAT: begin
               if (!step_in) begin
                  state_nxt = ST_IDLE;
               end else if (cnt == RATE_TERM) begin
                  cnt_nxt  = '0;
                  tick_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            ST_AUTO: begin
               if (!run_in) begin
                  state_nxt = ST_IDLE;
               end else if (cnt == AUTO_TERM) begin
                  cnt_nxt  = '0;
                  tick_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            ST_HALTED: begin
               if (!step_in && !run_in) state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign tick    = tick_q;
   assign running = (state == ST_AUTO) || (state == ST_REPEAT);
   assign halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb/tb_step_clock_ctrl.sv - directed self-checking bench for step_clock_ctrl
module tb_step_clock_ctrl;

   logic clock = 1'b0;
   logic reset_n;
   logic step_in;
   logic run_in;
   logic hlt;
   logic tick;
   logic running;
   logic halted;

   int passed = 0;
   int total  = 0;
   int nt;

   step_clock_ctrl #(
      .AUTO_DIV     (4),
      .REPEAT_DELAY (8),
      .REPEAT_RATE  (3)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .step_in (step_in),
      .run_in  (run_in),
      .hlt     (hlt),
      .tick    (tick),
      .running (running),
      .halted  (halted)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic outs(input string tag, input logic et, input logic er, input logic eh);
      chk({tag, " tick"}, {31'd0, tick}, {31'd0, et});
      chk({tag, " running"}, {31'd0, running}, {31'd0, er});
      chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
   endtask

   task automatic cyc(input string tag, input logic et, input logic er, input logic eh);
      @(posedge clock);
      #1;
      outs(tag, et, er, eh);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      step_in = 1'b0;
      run_in  = 1'b0;
      hlt     = 1'b0;

      // reset state
      cyc("reset0", 1'b0, 1'b0, 1'b0);
      cyc("reset1", 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc("idle", 1'b0, 1'b0, 1'b0);

      // short press: one tick in the cycle after the edge
      step_in = 1'b1;
      cyc("press0", 1'b1, 1'b0, 1'b0);
      cyc("press1", 1'b0, 1'b0, 1'b0);
      cyc("press2", 1'b0, 1'b0, 1'b0);
      step_in = 1'b0;
      cyc("release0", 1'b0, 1'b0, 1'b0);
      cyc("release1", 1'b0, 1'b0, 1'b0);

      // long hold: first tick, 8 held cycles, then every 3 cycles; release on terminal gives no tick
      step_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("hold%0d", i), (i == 0 || i == 11 || i == 14 || i == 17),
             (i >= 8), 1'b0);
      end
      step_in = 1'b0;
      cyc("hold_release", 1'b0, 1'b0, 1'b0);
      cyc("hold_idle", 1'b0, 1'b0, 1'b0);

      // auto run: run beats a simultaneous step edge, step edges ignored, ticks every 4 cycles
      run_in = 1'b1;
      nt = 0;
      for (int i = 0; i < 20; i++) begin
         step_in = (i == 0 || i == 1 || i == 5 || i == 6 || i == 9);
         cyc($sformatf("auto%0d", i), (i == 4 || i == 8 || i == 12 || i == 16), 1'b1, 1'b0);
         if (i < 17) nt += int'(tick);
      end
      chk("auto tick count", nt, 4);
      run_in = 1'b0;
      cyc("auto_stop_terminal", 1'b0, 1'b0, 1'b0);
      cyc("auto_idle", 1'b0, 1'b0, 1'b0);

      // halt during auto, halt held on terminal suppresses the tick
      run_in = 1'b1;
      cyc("halt_a0", 1'b0, 1'b1, 1'b0);
      cyc("halt_a1", 1'b0, 1'b1, 1'b0);
      cyc("halt_a2", 1'b0, 1'b1, 1'b0);
      hlt = 1'b1;
      cyc("halt_enter", 1'b0, 1'b0, 1'b1);
      cyc("halt_hold", 1'b0, 1'b0, 1'b1);
      hlt = 1'b0;
      cyc("halt_run_still", 1'b0, 1'b0, 1'b1);
      run_in = 1'b0;
      cyc("halt_exit", 1'b0, 1'b0, 1'b0);

      // halt with a step edge in IDLE: no tick, stays halted while step held
      step_in = 1'b1;
      hlt = 1'b1;
      cyc("halt_step", 1'b0, 1'b0, 1'b1);
      hlt = 1'b0;
      cyc("halt_step_held", 1'b0, 1'b0, 1'b1);
      step_in = 1'b0;
      cyc("halt_step_exit", 1'b0, 1'b0, 1'b0);

      // reset release with switch held: no tick until a fresh press
      step_in = 1'b1;
      reset_n = 1'b0;
      cyc("rst_held", 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc("rst_rel0", 1'b0, 1'b0, 1'b0);
      cyc("rst_rel1", 1'b0, 1'b0, 1'b0);
      step_in = 1'b0;
      cyc("rst_lift", 1'b0, 1'b0, 1'b0);
      step_in = 1'b1;
      cyc("rst_press", 1'b1, 1'b0, 1'b0);
      cyc("rst_press_held", 1'b0, 1'b0, 1'b0);
      step_in = 1'b0;
      cyc("rst_press_rel", 1'b0, 1'b0, 1'b0);

      // reset in the tick cycle drops tick immediately
      step_in = 1'b1;
      cyc("mid_tick", 1'b1, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      outs("async_rst", 1'b0, 1'b0, 1'b0);
      cyc("async_rst1", 1'b0, 1'b0, 1'b0);
      cyc("async_rst2", 1'b0, 1'b0, 1'b0);
      step_in = 1'b0;
      reset_n = 1'b1;
      cyc("async_rel0", 1'b0, 1'b0, 1'b0);
      cyc("async_rel1", 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
